// File: rtl/cle_serial_reader.sv
// Host-side reader for the CLE3 serial-data PAL: one command becomes a burst of
// single-bit bus reads, assembled MSB-first and returned on a valid/ready port.
module cle_serial_reader #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_addr,
  input  logic [CNT_W-1:0]  cmd_nbits,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  input  logic              sdrd,
  output logic              sser,
  output logic              ba13,
  output logic              ba12,
  output logic [3:0]        ba_lo,
  output logic              br_w,
  output logic              pal_clk
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_CLKH   = 3'd4;
  localparam logic [2:0] S_CLKL   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [CNT_W-1:0] WORD_W_C  = CNT_W'(WORD_W);
  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        wait_q, wait_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  nbits_eff;
  logic              bus_act;

  logic              cmd_ready_q, rd_valid_q, sser_q, ba13_q, ba12_q, br_w_q, pal_clk_q;
  logic [3:0]        ba_lo_q;
  logic [WORD_W-1:0] rd_data_q;

  assign nbits_eff = ((cmd_nbits == '0) || (cmd_nbits > WORD_W_C)) ? WORD_W_C : cmd_nbits;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = S_SETUP;
          addr_d    = cmd_addr;
          bit_cnt_d = nbits_eff;
          shreg_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_WAIT;
        wait_d  = SETTLE_M1;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_SAMPLE;
        else              wait_d  = wait_q - 4'd1;
      end
      S_SAMPLE: begin
        shreg_d = {shreg_q[WORD_W-2:0], sdrd};
        state_d = S_CLKH;
      end
      S_CLKH: state_d = S_CLKL;
      S_CLKL: begin
        // Saturating decrement: a count of 1 (or a stray 0) ends the burst.
        bit_cnt_d = (bit_cnt_q != '0) ? bit_cnt_q - CNT_W'(1) : '0;
        state_d   = (bit_cnt_q > CNT_W'(1)) ? S_SETUP : S_DONE;
      end
      S_DONE: begin
        if (rd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it.
  assign bus_act = (state_d != S_IDLE) && (state_d != S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bit_cnt_q   <= '0;
      wait_q      <= '0;
      shreg_q     <= '0;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      sser_q      <= 1'b1;
      ba13_q      <= 1'b1;
      ba12_q      <= 1'b0;
      ba_lo_q     <= '0;
      br_w_q      <= 1'b1;
      pal_clk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_q      <= wait_d;
      shreg_q     <= shreg_d;
      cmd_ready_q <= (state_d == S_IDLE);
      rd_valid_q  <= (state_d == S_DONE);
      rd_data_q   <= (state_d == S_DONE) ? shreg_d : '0;
      sser_q      <= !bus_act;
      ba13_q      <= !bus_act;
      ba12_q      <= bus_act;
      ba_lo_q     <= bus_act ? addr_d : '0;
      br_w_q      <= 1'b1;
      pal_clk_q   <= (state_d == S_CLKH);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign sser      = sser_q;
  assign ba13      = ba13_q;
  assign ba12      = ba12_q;
  assign ba_lo     = ba_lo_q;
  assign br_w      = br_w_q;
  assign pal_clk   = pal_clk_q;

endmodule

// File: tb/tb_cle_serial_reader.sv
// Directed bench for cle_serial_reader: PAL bit-stream model, result scoreboard
// and a bus monitor watching address stability and pal_clk placement.
module tb_cle_serial_reader;
  localparam int WORD_W     = 16;
  localparam int SETTLE_CYC = 2;
  localparam int CNT_W      = 5;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          pulses;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_addr = '0;
  logic [CNT_W-1:0]  cmd_nbits = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              sdrd;
  logic              sser, ba13, ba12, br_w, pal_clk;
  logic [3:0]        ba_lo;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pulse_cnt = 0;
  logic [31:0] pal_word = '0;
  logic        pal_fill = 1'b0;
  logic [3:0]  cur_addr = '0;
  logic        prev_pal = 1'b0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // PAL model: presents the head of its bit stream, advances on each pal_clk rise.
  assign sdrd = pal_word[31];
  always @(posedge pal_clk) begin
    pal_word = {pal_word[30:0], pal_fill};
    pulse_cnt++;
  end

  cle_serial_reader #(.WORD_W(WORD_W), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_nbits(cmd_nbits), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .sdrd(sdrd), .sser(sser),
    .ba13(ba13), .ba12(ba12), .ba_lo(ba_lo), .br_w(br_w), .pal_clk(pal_clk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] pat, input int nbits);
    int n;
    logic [15:0] w;
    n = (nbits == 0 || nbits > WORD_W) ? WORD_W : nbits;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[14:0], pat[31-i]};
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sser === 1'b0) begin
        check("mon_ba_lo", {28'd0, ba_lo}, {28'd0, cur_addr});
        check("mon_bus_bits", {29'd0, ba13, ba12, br_w}, 32'h3);
      end
      if (pal_clk === 1'b1) begin
        check("mon_clk_bus", {31'd0, sser}, 32'h0);
        check("mon_clk_width", {31'd0, prev_pal}, 32'h0);
      end
    end
    prev_pal = pal_clk;
  end

  // Called on a negedge with the DUT idle; returns on the negedge after accept.
  task automatic issue(input logic [3:0] a, input int nbits, input logic [31:0] pat,
                       input logic fill);
    exp_t e;
    int n;
    n = (nbits == 0 || nbits > WORD_W) ? WORD_W : nbits;
    pal_word  = pat;
    pal_fill  = fill;
    pulse_cnt = 0;
    cur_addr  = a;
    e.data    = model(pat, nbits);
    e.lat     = n * (SETTLE_CYC + 4);
    e.pulses  = n;
    sb.push_back(e);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_nbits = CNT_W'(nbits);
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    check("accept_busy", {30'd0, sser, cmd_ready}, 32'h0);
  endtask

  task automatic finish_cmd(input bit hold);
    exp_t e;
    logic [15:0] held;
    for (int i = 0; i < 4000 && rd_valid !== 1'b1; i++) @(negedge clk);
    check("rd_valid_timeout", {31'd0, rd_valid}, 32'h1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("rd_data", {16'd0, rd_data}, {16'd0, e.data});
      check("latency", cyc - acc_cyc, e.lat);
      check("pal_pulses", pulse_cnt, e.pulses);
    end
    if (hold) begin
      held = rd_data;
      for (int i = 0; i < 30; i++) begin
        cmd_valid = 1'b1;
        cmd_addr  = ~cur_addr;
        cmd_nbits = CNT_W'(3);
        @(negedge clk);
        check("hold_state", {29'd0, rd_valid, cmd_ready, sser}, 32'h5);
        check("hold_data", {16'd0, rd_data}, {16'd0, held});
      end
      cmd_valid = 1'b0;
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("rd_valid_drop", {31'd0, rd_valid}, 32'h0);
    check("rd_data_clr", {16'd0, rd_data}, 32'h0);
    check("cmd_ready_back", {31'd0, cmd_ready}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_bus", {25'd0, sser, ba13, ba12, br_w, pal_clk, cmd_ready, rd_valid}, 32'h6A);
      check("idle_lo", {12'd0, ba_lo, rd_data}, 32'h0);
    end

    issue(4'h2, 8, 32'hB200_0000, 1'b0);
    finish_cmd(1'b0);

    issue(4'h5, 0, 32'hFFFF_FFFF, 1'b1);
    finish_cmd(1'b0);
    issue(4'hC, 20, 32'hFFFF_FFFF, 1'b1);
    finish_cmd(1'b0);

    issue(4'hA, 4, 32'hA000_0000, 1'b0);
    finish_cmd(1'b1);
    repeat (3) @(negedge clk);
    check("no_queued_cmd", {30'd0, sser, cmd_ready}, 32'h3);
    issue(4'h3, 1, 32'h8000_0000, 1'b0);
    finish_cmd(1'b0);
    issue(4'h7, 16, 32'h5A3C_0000, 1'b0);
    finish_cmd(1'b0);

    issue(4'h9, 8, 32'hFF00_0000, 1'b0);
    for (int i = 0; i < 500 && pulse_cnt < 3; i++) @(negedge clk);
    check("bit3_clkh", {31'd0, pal_clk}, 32'h1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_bus", {25'd0, sser, ba13, ba12, br_w, pal_clk, cmd_ready, rd_valid}, 32'h6A);
    check("rst_lo", {12'd0, ba_lo, rd_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_pulse", pulse_cnt, 3);
    issue(4'h6, 4, 32'h6000_0000, 1'b0);
    finish_cmd(1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
